// File: rtl/rubiks_pkg.sv
// Shared types and constants for the Rubik's face LED display path.
// Holds the frame scheduler state encoding, the orientation word layout and
// the 3-bit colour codes that the scheduler and the colour mux agree on.
package rubiks_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } sched_state_t;

    localparam int unsigned SQUARE_W    = 3;
    localparam int unsigned NUM_SQUARES = 9;
    localparam int unsigned ORIENT_W    = 27;

    // Colour codes; BLANK drives the pixel dark
    localparam logic [SQUARE_W-1:0] COLOR_WHITE  = 3'd0;
    localparam logic [SQUARE_W-1:0] COLOR_YELLOW = 3'd1;
    localparam logic [SQUARE_W-1:0] COLOR_RED    = 3'd2;
    localparam logic [SQUARE_W-1:0] COLOR_ORANGE = 3'd3;
    localparam logic [SQUARE_W-1:0] COLOR_GREEN  = 3'd4;
    localparam logic [SQUARE_W-1:0] COLOR_BLUE   = 3'd5;
    localparam logic [SQUARE_W-1:0] COLOR_RSVD   = 3'd6;
    localparam logic [SQUARE_W-1:0] COLOR_BLANK  = 3'd7;

    localparam logic [ORIENT_W-1:0] ORIENT_BLANK = {NUM_SQUARES{COLOR_BLANK}};

    // Colour code of square n (0..8) within an orientation word
    function automatic logic [SQUARE_W-1:0] square_color(
        input logic [ORIENT_W-1:0] orient,
        input int unsigned         n
    );
        return orient[SQUARE_W*n +: SQUARE_W];
    endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and its neighbours.
//   orient_valid/orient_data/orient_ready : orientation intake from SPI capture
//   active_orient                         : orientation of the frame on the strip
//   pix_req/pix_index/pix_ack             : per-pixel handshake with the serializer
// slave  = scheduler side, master = capture/serializer side.
interface led_frame_scheduler_if #(
    parameter int unsigned NUM_LEDS = 64
);
    localparam int unsigned IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic                            orient_valid;
    logic [rubiks_pkg::ORIENT_W-1:0] orient_data;
    logic                            orient_ready;
    logic [rubiks_pkg::ORIENT_W-1:0] active_orient;
    logic                            pix_req;
    logic [IW-1:0]                   pix_index;
    logic                            pix_ack;

    modport slave (
        input  orient_valid,
        input  orient_data,
        output orient_ready,
        output active_orient,
        output pix_req,
        output pix_index,
        input  pix_ack
    );

    modport master (
        output orient_valid,
        output orient_data,
        input  orient_ready,
        input  active_orient,
        input  pix_req,
        input  pix_index,
        output pix_ack
    );

endinterface

// File: rtl/cycle_timer.sv
// Saturating cycle counter.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : count up by one, stopping at MAX-1
//   hit        : registered flag, high while the count equals MAX-1
module cycle_timer #(
    parameter int unsigned MAX = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned    CW   = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [CW-1:0]  LAST = CW'(MAX - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (en && (count != LAST)) begin
            count_nxt = count + CW'(1);
        end
    end

    // hit tracks count_nxt so it is a flop aligned with the count itself
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            hit   <= (MAX == 1);
        end else begin
            count <= count_nxt;
            hit   <= (count_nxt == LAST);
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// Full-frame refresh sequencer for the WS2812B face matrix.
// Takes a 27-bit face orientation into a shadow register, walks the LED chain
// handing one pixel at a time to the serializer, then holds the latch gap.
// A frame restarts on new data or when the idle refresh timer runs out.
//   clk, reset  : clock, async active-high reset
//   enable      : allows new frames to start; a running frame always completes
//   bus         : orientation intake + pixel req/ack handshake (slave side)
//   latch       : high during the latch gap (data line held low)
//   busy        : scheduler is not idle
//   frame_done  : one-cycle pulse in the last latch cycle
module led_frame_scheduler
    import rubiks_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 64,
    parameter int unsigned LATCH_CYCLES   = 2000,
    parameter int unsigned REFRESH_CYCLES = 400000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    led_frame_scheduler_if.slave  bus,
    output logic                  latch,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned   IW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);

    sched_state_t        state;
    sched_state_t        state_nxt;
    logic [IW-1:0]       pix_index;
    logic [IW-1:0]       pix_index_nxt;
    logic [ORIENT_W-1:0] active_orient;
    logic [ORIENT_W-1:0] active_nxt;
    logic [ORIENT_W-1:0] shadow;
    logic [ORIENT_W-1:0] shadow_nxt;
    logic                pending;
    logic                pending_nxt;
    logic                orient_ready;
    logic                pix_req;
    logic                refresh_due;
    logic                latch_clr_c;
    logic                latch_en_c;
    logic                refresh_en_c;

    assign bus.orient_ready  = orient_ready;
    assign bus.active_orient = active_orient;
    assign bus.pix_req       = pix_req;
    assign bus.pix_index     = pix_index;

    // Next-state, shadow capture and pixel walk
    always_comb begin
        state_nxt     = state;
        pix_index_nxt = pix_index;
        active_nxt    = active_orient;
        shadow_nxt    = shadow;
        pending_nxt   = pending;

        // orient_ready is ~pending, so a capture never collides with a LOAD clear
        if (bus.orient_valid && orient_ready) begin
            shadow_nxt  = bus.orient_data;
            pending_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (enable && (pending || refresh_due)) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // Without pending data this is a refresh of the current frame
                if (pending) begin
                    active_nxt  = shadow;
                    pending_nxt = 1'b0;
                end
                pix_index_nxt = '0;
                state_nxt     = SEND;
            end
            SEND: begin
                if (bus.pix_ack) begin
                    if (pix_index == LAST_IDX) begin
                        state_nxt = LATCH;
                    end else begin
                        pix_index_nxt = pix_index + IW'(1);
                    end
                end
            end
            LATCH: begin
                if (frame_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs, all decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pix_index     <= '0;
            active_orient <= ORIENT_BLANK;
            shadow        <= ORIENT_BLANK;
            pending       <= 1'b0;
            orient_ready  <= 1'b1;
            pix_req       <= 1'b0;
            latch         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            pix_index     <= pix_index_nxt;
            active_orient <= active_nxt;
            shadow        <= shadow_nxt;
            pending       <= pending_nxt;
            orient_ready  <= ~pending_nxt;
            pix_req       <= (state_nxt == SEND);
            latch         <= (state_nxt == LATCH);
            busy          <= (state_nxt != IDLE);
        end
    end

    // Latch gap: counts 1..LATCH_CYCLES across the LATCH cycles, so its hit
    // flag is exactly the last latch cycle and serves directly as frame_done.
    assign latch_en_c  = (state_nxt == LATCH);
    assign latch_clr_c = ~latch_en_c;

    cycle_timer #(
        .MAX (LATCH_CYCLES + 1)
    ) u_latch_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (latch_clr_c),
        .en    (latch_en_c),
        .hit   (frame_done)
    );

    // Idle refresh timer: runs only in IDLE, restarts at each frame end
    assign refresh_en_c = (state == IDLE);

    cycle_timer #(
        .MAX (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (frame_done),
        .en    (refresh_en_c),
        .hit   (refresh_due)
    );

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with a small orientation scoreboard.
module tb_led_frame_scheduler;

    localparam int unsigned NUM_LEDS       = 4;
    localparam int unsigned LATCH_CYCLES   = 5;
    localparam int unsigned REFRESH_CYCLES = 50;

    localparam logic [26:0] BLANK  = 27'h7FFFFFF;
    localparam logic [26:0] ORIENT = 27'h0000049;
    localparam logic [26:0] INJ_A  = 27'h1234567;
    localparam logic [26:0] JUNK_B = 27'h2AAAAAA;
    localparam logic [26:0] JUNK_C = 27'h5555555;
    localparam logic [26:0] INJ_D  = 27'h0FEDCBA;

    logic clk;
    logic reset;
    logic enable;
    logic latch;
    logic busy;
    logic frame_done;

    int checks = 0;
    int errors = 0;
    logic [26:0] sb[$];

    led_frame_scheduler_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    led_frame_scheduler #(
        .NUM_LEDS       (NUM_LEDS),
        .LATCH_CYCLES   (LATCH_CYCLES),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .latch      (latch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serve one frame: ack each pixel 2 cycles after its request, optionally
    // inject orientations mid-frame, pulse ack in the latch gap, or reset
    // the design while pixel reset_at is being requested.
    task automatic run_frame(input bit inject, input logic [26:0] inj_val,
                             input bit junk, input bit ack_latch, input int reset_at);
        int n;
        int fd_seen;
        int fd_pos;
        logic [26:0] exp_o;
        n = 0;
        while (bus.pix_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("req_start", 32'(bus.pix_req), 32'd1);
        if (bus.pix_req !== 1'b1) return;
        exp_o = 'x;
        if (sb.size() != 0) exp_o = sb.pop_front();
        chk("active_orient", 32'(bus.active_orient), 32'(exp_o));
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            chk("pix_req", 32'(bus.pix_req), 32'd1);
            chk("pix_index", 32'(bus.pix_index), 32'(i));
            if (i == reset_at) begin
                #2;
                reset = 1'b1;
                #1;
                chk("rst_pix_req", 32'(bus.pix_req), 32'd0);
                chk("rst_latch", 32'(latch), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_active", 32'(bus.active_orient), 32'(BLANK));
                chk("rst_pix_index", 32'(bus.pix_index), 32'd0);
                chk("rst_ready", 32'(bus.orient_ready), 32'd1);
                sb.delete();
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (inject && i == 1) begin
                chk("ready_before_inj", 32'(bus.orient_ready), 32'd1);
                bus.orient_valid = 1'b1;
                bus.orient_data  = inj_val;
                sb.push_back(inj_val);
            end else if (junk && i >= 2) begin
                chk("ready_held_off", 32'(bus.orient_ready), 32'd0);
                bus.orient_valid = 1'b1;
                bus.orient_data  = (i == 2) ? JUNK_B : JUNK_C;
            end
            tick();
            bus.orient_valid = 1'b0;
            if (inject && i == 1) chk("ready_after_inj", 32'(bus.orient_ready), 32'd0);
            chk("req_hold", 32'(bus.pix_req), 32'd1);
            chk("index_hold", 32'(bus.pix_index), 32'(i));
            tick();
            bus.pix_ack = 1'b1;
            tick();
            bus.pix_ack = 1'b0;
        end
        chk("req_low_latch", 32'(bus.pix_req), 32'd0);
        n = 0;
        fd_seen = 0;
        fd_pos = -1;
        while (latch === 1'b1 && n < 20) begin
            if (frame_done === 1'b1) begin
                fd_seen++;
                fd_pos = n;
            end
            if (ack_latch && n == 1) bus.pix_ack = 1'b1;
            tick();
            bus.pix_ack = 1'b0;
            n++;
            if (ack_latch && n == 2) chk("idx_after_latch_ack", 32'(bus.pix_index), 32'(NUM_LEDS - 1));
        end
        chk("latch_len", 32'(n), 32'(LATCH_CYCLES));
        chk("frame_done_cnt", 32'(fd_seen), 32'd1);
        chk("frame_done_pos", 32'(fd_pos), 32'(LATCH_CYCLES - 1));
        chk("frame_done_low", 32'(frame_done), 32'd0);
    endtask

    initial begin
        int n;
        logic busy_seen;
        reset = 1'b1;
        enable = 1'b0;
        bus.orient_valid = 1'b0;
        bus.orient_data = '0;
        bus.pix_ack = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("reset_ready", 32'(bus.orient_ready), 32'd1);
        chk("reset_pix_req", 32'(bus.pix_req), 32'd0);
        chk("reset_latch", 32'(latch), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_pix_index", 32'(bus.pix_index), 32'd0);
        chk("reset_active", 32'(bus.active_orient), 32'(BLANK));

        // Idle refresh frame after the timer reaches REFRESH_CYCLES-1
        reset = 1'b0;
        enable = 1'b1;
        sb.push_back(BLANK);
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("refresh_start", 32'(n), 32'(REFRESH_CYCLES));
        run_frame(1'b0, '0, 1'b0, 1'b0, -1);

        // New orientation: check the accept -> LOAD -> SEND latency
        chk("ready_idle", 32'(bus.orient_ready), 32'd1);
        bus.orient_valid = 1'b1;
        bus.orient_data = ORIENT;
        sb.push_back(ORIENT);
        tick();
        bus.orient_valid = 1'b0;
        chk("ready_after_accept", 32'(bus.orient_ready), 32'd0);
        chk("busy_after_e0", 32'(busy), 32'd0);
        tick();
        chk("busy_load", 32'(busy), 32'd1);
        chk("req_load", 32'(bus.pix_req), 32'd0);
        chk("active_in_load", 32'(bus.active_orient), 32'(BLANK));
        tick();
        chk("req_after_e2", 32'(bus.pix_req), 32'd1);
        chk("active_after_e2", 32'(bus.active_orient), 32'(ORIENT));
        run_frame(1'b1, INJ_A, 1'b1, 1'b1, -1);

        // enable low holds IDLE with data pending; ack in IDLE ignored
        chk("idle_after_frame", 32'(busy), 32'd0);
        enable = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.pix_ack = (i == 10);
            tick();
            busy_seen = busy_seen | busy;
        end
        bus.pix_ack = 1'b0;
        chk("hold_idle", 32'(busy_seen), 32'd0);
        chk("idle_ack_index", 32'(bus.pix_index), 32'(NUM_LEDS - 1));
        chk("pending_kept", 32'(bus.orient_ready), 32'd0);
        enable = 1'b1;
        tick();
        chk("enable_load", 32'(busy), 32'd1);
        chk("enable_load_req", 32'(bus.pix_req), 32'd0);
        run_frame(1'b1, INJ_D, 1'b0, 1'b0, -1);

        // Queued data restarts a frame straight after frame_done
        chk("restart_idle", 32'(busy), 32'd0);
        tick();
        chk("restart_load", 32'(busy), 32'd1);
        run_frame(1'b0, '0, 1'b0, 1'b0, 2);

        tick();
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_active", 32'(bus.active_orient), 32'(BLANK));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
